parking_occupancy_ctrl: RTL and testbench



---
 rtl/parking_occupancy_ctrl_pkg.sv | 57 +++++
 rtl/parking_class_counter.sv | 111 +++++++++++
 rtl/parking_occupancy_ctrl.sv | 106 ++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_occupancy_ctrl_pkg.sv
// Capacity schedule, class encoding and the hour-to-capacity lookup shared by the parking controller.
// Pure declarations; no latency and no backpressure.
package parking_pkg;

  localparam int unsigned TOTAL_CAP = 700;
  localparam int unsigned OPEN_HOUR = 8;
  localparam int          CAP_W     = 10;

  typedef logic [CAP_W-1:0] cap_t;

  typedef enum logic {
    CLASS_UNI = 1'b0,
    CLASS_GEN = 1'b1
  } class_e;

  typedef struct packed {
    cap_t uni;
    cap_t gen;
  } cap_pair_t;

  localparam cap_t CAP_UNI_DAY = 10'd500;
  localparam cap_t CAP_GEN_DAY = 10'd200;
  localparam cap_t CAP_UNI_14  = 10'd450;
  localparam cap_t CAP_GEN_14  = 10'd250;
  localparam cap_t CAP_UNI_15  = 10'd400;
  localparam cap_t CAP_GEN_15  = 10'd300;
  localparam cap_t CAP_UNI_16  = 10'd350;
  localparam cap_t CAP_GEN_16  = 10'd350;
  localparam cap_t CAP_UNI_EVE = 10'd200;
  localparam cap_t CAP_GEN_EVE = 10'd500;

  // Every open bucket splits TOTAL_CAP between the two classes.
  function automatic cap_pair_t cap_lookup(input logic [31:0] hour);
    cap_pair_t c;
    if (hour < OPEN_HOUR) begin
      c.uni = '0;
      c.gen = '0;
    end else if (hour <= 32'd13) begin
      c.uni = CAP_UNI_DAY;
      c.gen = CAP_GEN_DAY;
    end else if (hour == 32'd14) begin
      c.uni = CAP_UNI_14;
      c.gen = CAP_GEN_14;
    end else if (hour == 32'd15) begin
      c.uni = CAP_UNI_15;
      c.gen = CAP_GEN_15;
    end else if (hour == 32'd16) begin
      c.uni = CAP_UNI_16;
      c.gen = CAP_GEN_16;
    end else begin
      c.uni = CAP_UNI_EVE;
      c.gen = CAP_GEN_EVE;
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_class_counter.sv
// Per-class occupancy tracker: ordered exit-then-entry allocation across all gates against one capacity.
// Responses and status registered, 1-cycle latency; no backpressure (every request answered).
module parking_class_counter
  import parking_pkg::*;
#(
  parameter int     NUM_GATES = 4,
  parameter int     CNT_W     = 16,
  parameter class_e CLS       = CLASS_UNI
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  cap_t                 i_cap,
  input  logic [NUM_GATES-1:0] i_ent_req,
  input  logic [NUM_GATES-1:0] i_ent_uni,
  input  logic [NUM_GATES-1:0] i_ext_req,
  input  logic [NUM_GATES-1:0] i_ext_uni,
  output logic [NUM_GATES-1:0] o_grant,
  output logic [NUM_GATES-1:0] o_deny,
  output logic [NUM_GATES-1:0] o_ack,
  output logic [NUM_GATES-1:0] o_err,
  output logic [CNT_W-1:0]     o_parked,
  output logic [CNT_W-1:0]     o_free,
  output logic                 o_avail,
  output logic                 o_over
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NUM_GATES-1:0] w_ent_m;
  logic [NUM_GATES-1:0] w_ext_m;
  logic [CNT_W-1:0]     w_cap;
  logic [CNT_W-1:0]     w_occ;
  logic [NUM_GATES-1:0] w_grant;
  logic [NUM_GATES-1:0] w_deny;
  logic [NUM_GATES-1:0] w_ack;
  logic [NUM_GATES-1:0] w_err;

  logic [CNT_W-1:0]     r_occ;
  logic [CNT_W-1:0]     r_free;
  logic                 r_avail;
  logic                 r_over;
  logic [NUM_GATES-1:0] r_grant;
  logic [NUM_GATES-1:0] r_deny;
  logic [NUM_GATES-1:0] r_ack;
  logic [NUM_GATES-1:0] r_err;

  assign w_ent_m = i_ent_req & ((CLS == CLASS_UNI) ? i_ent_uni : ~i_ent_uni);
  assign w_ext_m = i_ext_req & ((CLS == CLASS_UNI) ? i_ext_uni : ~i_ext_uni);
  assign w_cap   = CNT_W'(i_cap);

  // Exits run first so that spaces freed this cycle are visible to the entries below.
  always_comb begin
    w_occ   = r_occ;
    w_grant = '0;
    w_deny  = '0;
    w_ack   = '0;
    w_err   = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      if (w_ext_m[g]) begin
        if (w_occ != '0) begin
          w_ack[g] = 1'b1;
          w_occ    = w_occ - ONE;
        end else begin
          w_err[g] = 1'b1;
        end
      end
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      if (w_ent_m[g]) begin
        if (w_occ < w_cap) begin
          w_grant[g] = 1'b1;
          w_occ      = w_occ + ONE;
        end else begin
          w_deny[g] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ   <= '0;
      r_free  <= '0;
      r_avail <= 1'b0;
      r_over  <= 1'b0;
      r_grant <= '0;
      r_deny  <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      r_occ   <= w_occ;
      r_free  <= (w_occ < w_cap) ? (w_cap - w_occ) : '0;
      r_avail <= (w_occ < w_cap);
      r_over  <= (w_occ > w_cap);
      r_grant <= w_grant;
      r_deny  <= w_deny;
      r_ack   <= w_ack;
      r_err   <= w_err;
    end
  end

  assign o_parked = r_occ;
  assign o_free   = r_free;
  assign o_avail  = r_avail;
  assign o_over   = r_over;
  assign o_grant  = r_grant;
  assign o_deny   = r_deny;
  assign o_ack    = r_ack;
  assign o_err    = r_err;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Two-class multi-gate parking controller: hour-driven capacity registers feeding one counter per class.
// Capacity reg 1 cycle after hour change, responses 1 cycle after request; no backpressure.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_GATES = 4,
  parameter int CNT_W     = 16,
  parameter int HOUR_W    = 12
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic [HOUR_W-1:0]    hour_i,
  input  logic [NUM_GATES-1:0] ent_req,
  input  logic [NUM_GATES-1:0] ent_uni,
  input  logic [NUM_GATES-1:0] ext_req,
  input  logic [NUM_GATES-1:0] ext_uni,
  output logic [NUM_GATES-1:0] ent_grant,
  output logic [NUM_GATES-1:0] ent_deny,
  output logic [NUM_GATES-1:0] ext_ack,
  output logic [NUM_GATES-1:0] ext_err,
  output logic [CNT_W-1:0]     uni_parked,
  output logic [CNT_W-1:0]     gen_parked,
  output logic [CNT_W-1:0]     uni_free,
  output logic [CNT_W-1:0]     gen_free,
  output logic                 uni_avail,
  output logic                 gen_avail,
  output logic                 uni_over,
  output logic                 gen_over,
  output logic                 cap_chg
);

  cap_pair_t w_cap_nxt;
  cap_t      r_cap_uni;
  cap_t      r_cap_gen;
  logic      r_cap_chg;

  logic [NUM_GATES-1:0] w_uni_grant, w_uni_deny, w_uni_ack, w_uni_err;
  logic [NUM_GATES-1:0] w_gen_grant, w_gen_deny, w_gen_ack, w_gen_err;

  assign w_cap_nxt = cap_lookup(32'(hour_i));

  // Reset forces capacity to 0, so the first reload after reset pulses cap_chg for an open lot.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      r_cap_uni <= '0;
      r_cap_gen <= '0;
      r_cap_chg <= 1'b0;
    end else begin
      r_cap_uni <= w_cap_nxt.uni;
      r_cap_gen <= w_cap_nxt.gen;
      r_cap_chg <= (w_cap_nxt.uni != r_cap_uni) || (w_cap_nxt.gen != r_cap_gen);
    end
  end

  parking_class_counter #(
    .NUM_GATES(NUM_GATES),
    .CNT_W    (CNT_W),
    .CLS      (CLASS_UNI)
  ) u_uni (
    .i_clk    (core_clk),
    .i_rst    (rst),
    .i_cap    (r_cap_uni),
    .i_ent_req(ent_req),
    .i_ent_uni(ent_uni),
    .i_ext_req(ext_req),
    .i_ext_uni(ext_uni),
    .o_grant  (w_uni_grant),
    .o_deny   (w_uni_deny),
    .o_ack    (w_uni_ack),
    .o_err    (w_uni_err),
    .o_parked (uni_parked),
    .o_free   (uni_free),
    .o_avail  (uni_avail),
    .o_over   (uni_over)
  );

  parking_class_counter #(
    .NUM_GATES(NUM_GATES),
    .CNT_W    (CNT_W),
    .CLS      (CLASS_GEN)
  ) u_gen (
    .i_clk    (core_clk),
    .i_rst    (rst),
    .i_cap    (r_cap_gen),
    .i_ent_req(ent_req),
    .i_ent_uni(ent_uni),
    .i_ext_req(ext_req),
    .i_ext_uni(ext_uni),
    .o_grant  (w_gen_grant),
    .o_deny   (w_gen_deny),
    .o_ack    (w_gen_ack),
    .o_err    (w_gen_err),
    .o_parked (gen_parked),
    .o_free   (gen_free),
    .o_avail  (gen_avail),
    .o_over   (gen_over)
  );

  // Class masks make the two counters' responses disjoint per gate, so OR is a safe merge.
  assign ent_grant = w_uni_grant | w_gen_grant;
  assign ent_deny  = w_uni_deny  | w_gen_deny;
  assign ext_ack   = w_uni_ack   | w_gen_ack;
  assign ext_err   = w_uni_err   | w_gen_err;
  assign cap_chg   = r_cap_chg;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl: directed vectors push expected gate responses,
// a negedge monitor pops and compares whenever any response bit is raised.
module tb_parking_occupancy_ctrl;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] deny;
    logic [3:0] ack;
    logic [3:0] err;
  } rsp_t;

  logic        core_clk = 1'b0;
  logic        rst;
  logic [11:0] hour_i;
  logic [3:0]  ent_req, ent_uni, ext_req, ext_uni;
  logic [3:0]  ent_grant, ent_deny, ext_ack, ext_err;
  logic [15:0] uni_parked, gen_parked, uni_free, gen_free;
  logic        uni_avail, gen_avail, uni_over, gen_over, cap_chg;

  int   tests = 0;
  int   fails = 0;
  rsp_t exp_q[$];

  always #5 core_clk = ~core_clk;

  parking_occupancy_ctrl #(.NUM_GATES(4), .CNT_W(16), .HOUR_W(12)) dut (
    .core_clk  (core_clk),
    .rst       (rst),
    .hour_i    (hour_i),
    .ent_req   (ent_req),
    .ent_uni   (ent_uni),
    .ext_req   (ext_req),
    .ext_uni   (ext_uni),
    .ent_grant (ent_grant),
    .ent_deny  (ent_deny),
    .ext_ack   (ext_ack),
    .ext_err   (ext_err),
    .uni_parked(uni_parked),
    .gen_parked(gen_parked),
    .uni_free  (uni_free),
    .gen_free  (gen_free),
    .uni_avail (uni_avail),
    .gen_avail (gen_avail),
    .uni_over  (uni_over),
    .gen_over  (gen_over),
    .cap_chg   (cap_chg)
  );

  always @(negedge core_clk) begin
    rsp_t got;
    rsp_t want;
    got = {ent_grant, ent_deny, ext_ack, ext_err};
    if (got != '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got g=%b d=%b a=%b e=%b, expected no response",
                 got.grant, got.deny, got.ack, got.err);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          fails++;
          $display("FAIL gate_rsp: got g=%b d=%b a=%b e=%b, expected g=%b d=%b a=%b e=%b",
                   got.grant, got.deny, got.ack, got.err,
                   want.grant, want.deny, want.ack, want.err);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] er, input logic [3:0] eu,
                      input logic [3:0] xr, input logic [3:0] xu);
    ent_req = er;
    ent_uni = eu;
    ext_req = xr;
    ext_uni = xu;
    @(posedge core_clk);
    #1;
    ent_req = 4'b0;
    ent_uni = 4'b0;
    ext_req = 4'b0;
    ext_uni = 4'b0;
  endtask

  task automatic idle();
    step(4'b0, 4'b0, 4'b0, 4'b0);
  endtask

  task automatic req(input logic [3:0] er, input logic [3:0] eu,
                     input logic [3:0] xr, input logic [3:0] xu,
                     input logic [3:0] g, input logic [3:0] d,
                     input logic [3:0] a, input logic [3:0] e);
    exp_q.push_back({g, d, a, e});
    step(er, eu, xr, xu);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    hour_i  = 12'd9;
    ent_req = 4'b0;
    ent_uni = 4'b0;
    ext_req = 4'b0;
    ext_uni = 4'b0;
    repeat (3) idle();
    chk("rst_uni_parked", int'(uni_parked), 0);
    chk("rst_gen_parked", int'(gen_parked), 0);
    chk("rst_uni_free",   int'(uni_free),   0);
    chk("rst_gen_free",   int'(gen_free),   0);
    chk("rst_avail",      int'({uni_avail, gen_avail}), 0);
    chk("rst_over",       int'({uni_over, gen_over}),   0);
    chk("rst_cap_chg",    int'(cap_chg),    0);
    chk("rst_rsp",        int'({ent_grant, ent_deny, ext_ack, ext_err}), 0);

    rst = 1'b0;
    idle();
    chk("cap_chg_first_load", int'(cap_chg), 1);
    idle();
    chk("cap_chg_settled", int'(cap_chg),  0);
    chk("uni_free_500",    int'(uni_free), 500);
    chk("gen_free_200",    int'(gen_free), 200);
    chk("uni_avail_open",  int'(uni_avail), 1);

    // Fill the university class one car per cycle.
    for (int i = 0; i < 500; i++)
      req(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    chk("uni_parked_500", int'(uni_parked), 500);
    chk("uni_free_full",  int'(uni_free),   0);
    chk("uni_avail_full", int'(uni_avail),  0);
    chk("uni_over_full",  int'(uni_over),   0);
    req(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0);
    chk("uni_501st_denied_cnt", int'(uni_parked), 500);

    // Full class: the exit on gate 3 frees one space for gate 0 only.
    req(4'b0011, 4'b0011, 4'b1000, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0);
    chk("uni_swap_cnt", int'(uni_parked), 500);

    for (int i = 0; i < 49; i++)
      req(4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0);
    for (int i = 0; i < 3; i++)
      req(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    chk("gen_parked_199", int'(gen_parked), 199);
    chk("gen_free_1",     int'(gen_free),   1);
    hour_i = 12'd10;
    idle();
    chk("cap_chg_same_bucket", int'(cap_chg), 0);
    req(4'b0111, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0110, 4'b0, 4'b0);
    chk("gen_parked_200", int'(gen_parked), 200);
    chk("gen_avail_full", int'(gen_avail),  0);

    for (int i = 0; i < 5; i++)
      req(4'b0, 4'b0, 4'b1111, 4'b1111, 4'b0, 4'b0, 4'b1111, 4'b0);
    chk("uni_parked_480", int'(uni_parked), 480);
    chk("uni_free_20",    int'(uni_free),   20);
    hour_i = 12'd13;
    idle();
    chk("cap_chg_hour13", int'(cap_chg), 0);

    // Schedule reduction to 400/300 below current uni occupancy.
    hour_i = 12'd15;
    idle();
    chk("cap_chg_hour15", int'(cap_chg), 1);
    idle();
    chk("cap_chg_hour15_off", int'(cap_chg), 0);
    chk("uni_over_reduce",    int'(uni_over),  1);
    chk("uni_free_reduce",    int'(uni_free),  0);
    chk("uni_avail_reduce",   int'(uni_avail), 0);
    chk("uni_parked_kept",    int'(uni_parked), 480);
    chk("gen_free_100",       int'(gen_free),  100);
    req(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0);
    for (int i = 0; i < 20; i++)
      req(4'b0, 4'b0, 4'b1111, 4'b1111, 4'b0, 4'b0, 4'b1111, 4'b0);
    chk("uni_parked_400", int'(uni_parked), 400);
    chk("uni_over_at_cap", int'(uni_over),  0);
    req(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0);
    req(4'b0, 4'b0, 4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0001, 4'b0);
    chk("uni_parked_399", int'(uni_parked), 399);
    chk("uni_free_1",     int'(uni_free),   1);
    chk("uni_avail_399",  int'(uni_avail),  1);
    req(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    chk("uni_parked_refill", int'(uni_parked), 400);

    // Lot closed: exits still counted, entries refused, exhausted exits flagged.
    hour_i = 12'd5;
    idle();
    chk("cap_chg_close", int'(cap_chg), 1);
    for (int i = 0; i < 49; i++)
      req(4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111, 4'b0);
    req(4'b0, 4'b0, 4'b0011, 4'b0, 4'b0, 4'b0, 4'b0011, 4'b0);
    chk("gen_parked_2", int'(gen_parked), 2);
    req(4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0011, 4'b1100);
    chk("gen_parked_0", int'(gen_parked), 0);
    req(4'b0101, 4'b0100, 4'b0010, 4'b0, 4'b0, 4'b0101, 4'b0, 4'b0010);
    chk("gen_closed_cnt",  int'(gen_parked), 0);
    chk("gen_closed_free", int'(gen_free),   0);
    chk("uni_closed_cnt",  int'(uni_parked), 400);

    for (int i = 0; i < 89; i++)
      req(4'b0, 4'b0, 4'b1111, 4'b1111, 4'b0, 4'b0, 4'b1111, 4'b0);
    req(4'b0, 4'b0, 4'b0011, 4'b0011, 4'b0, 4'b0, 4'b0011, 4'b0);
    chk("uni_parked_42", int'(uni_parked), 42);
    chk("uni_over_closed", int'(uni_over), 1);

    // Reset with requests pending: dropped, no response, counters cleared.
    rst = 1'b1;
    step(4'b0001, 4'b0001, 4'b0010, 4'b0010);
    chk("midrst_uni_parked", int'(uni_parked), 0);
    chk("midrst_gen_parked", int'(gen_parked), 0);
    chk("midrst_uni_over",   int'(uni_over),   0);
    chk("midrst_rsp", int'({ent_grant, ent_deny, ext_ack, ext_err}), 0);
    rst = 1'b0;
    idle();
    chk("postrst_rsp", int'({ent_grant, ent_deny, ext_ack, ext_err}), 0);
    chk("postrst_cap_chg_closed", int'(cap_chg), 0);
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
